sdram_arbit: RTL and testbench

- Standalone SDRAM command arbiter and scheduler.
- Sequences power-up init, then shares the single SDRAM command/address/data bus between three requesters: auto-refresh, write and read.
- Refresh always has priority; write and read share the bus round-robin.
- Drives the muxed SDRAM command, address, bank and DQ-output-enable, and issues one-cycle grant pulses to the requester modules.

---
 rtl/sdram_arbit.sv | 282 ++++++++++++++++++++++++++++
 tb/tb_sdram_arbit.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_arbit.sv
// ---------------------------------------------------------------------------
// sdram_arbit
//
// SDRAM command arbiter / scheduler. Holds the bus for the power-up init
// sequence, then shares the single SDRAM command/address/data bus between
// the auto-refresh, write and read requester modules. Refresh always wins;
// write and read alternate round-robin when both are asking.
//
// Optional feature (compile-time macro SDRAM_ARBIT_WDOG_EN):
//   Adds a watchdog that aborts a granted state (AREF/WRITE/READ) after
//   WDOG_CYCLES clocks without its done flag, returns to ARBIT and raises a
//   sticky wdog_err output. Without the macro the port and counter are absent
//   and granted states wait indefinitely for their done flag.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   flag_init_end             init sequence complete (pulse or level)
//   init_cmd/init_addr        init command and address, driven in IDLE
//   ref_req, flag_ref_end     refresh request pulse, refresh done
//   ref_cmd/ref_addr          refresh command and address
//   ref_en                    one-cycle refresh grant pulse
//   wr_req, flag_wr_end       write request (level), write burst done
//   wr_cmd/wr_addr/wr_bank    write command, address, bank
//   wr_data                   write data, forwarded to the DQ pad in WRITE
//   wr_en                     one-cycle write grant pulse
//   rd_req, flag_rd_end       read request (level), read burst done
//   rd_cmd/rd_addr/rd_bank    read command, address, bank
//   rd_en                     one-cycle read grant pulse
//   sdram_cmd/addr/bank       muxed SDRAM command bus {cs_n,ras_n,cas_n,we_n}
//   sdram_dq_out/sdram_dq_oe  DQ output data and output enable
//   arb_state                 one-hot state for debug
//   wdog_err                  sticky watchdog error (macro builds only)
// ---------------------------------------------------------------------------
module sdram_arbit #(
  parameter int ADDR_W      = 12,
  parameter int DATA_W      = 16,
  parameter int WDOG_CYCLES = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flag_init_end,
  input  logic [3:0]        init_cmd,
  input  logic [ADDR_W-1:0] init_addr,
  input  logic              ref_req,
  input  logic              flag_ref_end,
  input  logic [3:0]        ref_cmd,
  input  logic [ADDR_W-1:0] ref_addr,
  output logic              ref_en,
  input  logic              wr_req,
  input  logic              flag_wr_end,
  input  logic [3:0]        wr_cmd,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [1:0]        wr_bank,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_en,
  input  logic              rd_req,
  input  logic              flag_rd_end,
  input  logic [3:0]        rd_cmd,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic [1:0]        rd_bank,
  output logic              rd_en,
  output logic [3:0]        sdram_cmd,
  output logic [ADDR_W-1:0] sdram_addr,
  output logic [1:0]        sdram_bank,
  output logic [DATA_W-1:0] sdram_dq_out,
  output logic              sdram_dq_oe,
  output logic [4:0]        arb_state
`ifdef SDRAM_ARBIT_WDOG_EN
  ,
  output logic              wdog_err
`endif
);

  // One-hot state encodings
  localparam logic [4:0] IDLE  = 5'b00001;
  localparam logic [4:0] ARBIT = 5'b00010;
  localparam logic [4:0] AREF  = 5'b00100;
  localparam logic [4:0] WRITE = 5'b01000;
  localparam logic [4:0] READ  = 5'b10000;

  // Which of write/read was granted most recently
  localparam logic LAST_WR = 1'b0;
  localparam logic LAST_RD = 1'b1;

  localparam logic [3:0] CMD_NOP = 4'b0111;

  logic [4:0] state_r;
  logic [4:0] state_nxt_s;
  logic       last_rw_r;
  logic       last_rw_nxt_s;
  logic       ref_pend_r;
  logic       ref_pend_nxt_s;
  logic       ref_en_r;
  logic       wr_en_r;
  logic       rd_en_r;
  logic       ref_en_nxt_s;
  logic       wr_en_nxt_s;
  logic       rd_en_nxt_s;
  logic       wdog_trip_s;

`ifdef SDRAM_ARBIT_WDOG_EN
  localparam int WDOG_W = (WDOG_CYCLES > 1) ? $clog2(WDOG_CYCLES) : 1;

  logic [WDOG_W-1:0] wdog_cnt_r;
  logic              wdog_err_r;
  logic              granted_s;

  assign granted_s   = (state_r == AREF) || (state_r == WRITE) || (state_r == READ);
  // Count runs 0..WDOG_CYCLES-1 over the granted state's cycles; the trip
  // edge is therefore the end of the WDOG_CYCLES-th cycle in that state.
  assign wdog_trip_s = granted_s && (wdog_cnt_r == WDOG_W'(WDOG_CYCLES - 1));

  // Watchdog counter: runs in granted states, clears on every state entry
  always_ff @(posedge clk) begin
    if (rst) begin
      wdog_cnt_r <= {WDOG_W{1'b0}};
    end else if (state_nxt_s != state_r) begin
      wdog_cnt_r <= {WDOG_W{1'b0}};
    end else if (granted_s) begin
      wdog_cnt_r <= wdog_cnt_r + WDOG_W'(1);
    end else begin
      wdog_cnt_r <= {WDOG_W{1'b0}};
    end
  end

  // Sticky watchdog error flag; only rst clears it
  always_ff @(posedge clk) begin
    if (rst) begin
      wdog_err_r <= 1'b0;
    end else if (wdog_trip_s && (state_nxt_s == ARBIT)) begin
      wdog_err_r <= 1'b1;
    end else begin
      wdog_err_r <= wdog_err_r;
    end
  end

  assign wdog_err = wdog_err_r;
`else
  assign wdog_trip_s = 1'b0;
`endif

  // Next-state, grant and refresh-pending decision logic
  always_comb begin
    state_nxt_s   = state_r;
    last_rw_nxt_s = last_rw_r;
    ref_en_nxt_s  = 1'b0;
    wr_en_nxt_s   = 1'b0;
    rd_en_nxt_s   = 1'b0;
    // Refresh pulses are remembered everywhere except IDLE
    if ((state_r != IDLE) && ref_req) begin
      ref_pend_nxt_s = 1'b1;
    end else begin
      ref_pend_nxt_s = ref_pend_r;
    end

    case (state_r)
      IDLE: begin
        if (flag_init_end) begin
          state_nxt_s = ARBIT;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      ARBIT: begin
        if (ref_pend_r) begin
          state_nxt_s    = AREF;
          ref_en_nxt_s   = 1'b1;
          // A new pulse on the grant edge must not be lost
          ref_pend_nxt_s = ref_req;
        end else if (ref_req) begin
          // Pending bit is set this edge; hold the bus so write/read cannot
          // slip in ahead of the refresh.
          state_nxt_s = ARBIT;
        end else if (wr_req && rd_req) begin
          if (last_rw_r == LAST_RD) begin
            state_nxt_s   = WRITE;
            wr_en_nxt_s   = 1'b1;
            last_rw_nxt_s = LAST_WR;
          end else begin
            state_nxt_s   = READ;
            rd_en_nxt_s   = 1'b1;
            last_rw_nxt_s = LAST_RD;
          end
        end else if (wr_req) begin
          state_nxt_s   = WRITE;
          wr_en_nxt_s   = 1'b1;
          last_rw_nxt_s = LAST_WR;
        end else if (rd_req) begin
          state_nxt_s   = READ;
          rd_en_nxt_s   = 1'b1;
          last_rw_nxt_s = LAST_RD;
        end else begin
          state_nxt_s = ARBIT;
        end
      end
      AREF: begin
        if (flag_ref_end || wdog_trip_s) begin
          state_nxt_s = ARBIT;
        end else begin
          state_nxt_s = AREF;
        end
      end
      WRITE: begin
        if (flag_wr_end || wdog_trip_s) begin
          state_nxt_s = ARBIT;
        end else begin
          state_nxt_s = WRITE;
        end
      end
      READ: begin
        if (flag_rd_end || wdog_trip_s) begin
          state_nxt_s = ARBIT;
        end else begin
          state_nxt_s = READ;
        end
      end
      default: begin
        // Any non one-hot encoding falls back to IDLE
        state_nxt_s = IDLE;
      end
    endcase
  end

  // State, arbitration history and grant pulse registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= IDLE;
      last_rw_r  <= LAST_RD;
      ref_pend_r <= 1'b0;
      ref_en_r   <= 1'b0;
      wr_en_r    <= 1'b0;
      rd_en_r    <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      last_rw_r  <= last_rw_nxt_s;
      ref_pend_r <= ref_pend_nxt_s;
      ref_en_r   <= ref_en_nxt_s;
      wr_en_r    <= wr_en_nxt_s;
      rd_en_r    <= rd_en_nxt_s;
    end
  end

  assign ref_en    = ref_en_r;
  assign wr_en     = wr_en_r;
  assign rd_en     = rd_en_r;
  assign arb_state = state_r;

  // SDRAM bus mux selected by the current state
  always_comb begin
    sdram_cmd    = CMD_NOP;
    sdram_addr   = {ADDR_W{1'b0}};
    sdram_bank   = 2'b00;
    sdram_dq_out = {DATA_W{1'b0}};
    sdram_dq_oe  = 1'b0;
    case (state_r)
      IDLE: begin
        sdram_cmd  = init_cmd;
        sdram_addr = init_addr;
      end
      AREF: begin
        sdram_cmd  = ref_cmd;
        sdram_addr = ref_addr;
      end
      WRITE: begin
        sdram_cmd    = wr_cmd;
        sdram_addr   = wr_addr;
        sdram_bank   = wr_bank;
        sdram_dq_out = wr_data;
        sdram_dq_oe  = 1'b1;
      end
      READ: begin
        sdram_cmd  = rd_cmd;
        sdram_addr = rd_addr;
        sdram_bank = rd_bank;
      end
      default: begin
        sdram_cmd = CMD_NOP;
      end
    endcase
  end

endmodule

// File: tb/tb_sdram_arbit.sv
// ---------------------------------------------------------------------------
// tb_sdram_arbit
//
// Directed, table-driven bench for sdram_arbit. Each table row gives the
// control inputs applied for one clock and the state/grants expected right
// after that edge; bus-mux expectations are derived from the expected state.
// Hand-written sequences cover the round-robin burst loop and, in builds
// with SDRAM_ARBIT_WDOG_EN, the watchdog abort.
// ---------------------------------------------------------------------------
module tb_sdram_arbit;

  localparam int ADDR_W = 12;
  localparam int DATA_W = 16;

  localparam logic [4:0] S_IDLE  = 5'b00001;
  localparam logic [4:0] S_ARBIT = 5'b00010;
  localparam logic [4:0] S_AREF  = 5'b00100;
  localparam logic [4:0] S_WRITE = 5'b01000;
  localparam logic [4:0] S_READ  = 5'b10000;

  localparam logic [3:0]        C_INIT = 4'b0010;
  localparam logic [3:0]        C_REF  = 4'b0001;
  localparam logic [3:0]        C_WR   = 4'b0100;
  localparam logic [3:0]        C_RD   = 4'b0101;
  localparam logic [ADDR_W-1:0] A_INIT = 12'h400;
  localparam logic [ADDR_W-1:0] A_REF  = 12'h0F0;
  localparam logic [ADDR_W-1:0] A_WR   = 12'h123;
  localparam logic [ADDR_W-1:0] A_RD   = 12'h3C5;
  localparam logic [1:0]        B_WR   = 2'd1;
  localparam logic [1:0]        B_RD   = 2'd2;
  localparam logic [DATA_W-1:0] D_WR   = 16'hA5C3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic flag_init_end = 1'b0;
  logic ref_req = 1'b0, flag_ref_end = 1'b0;
  logic wr_req = 1'b0, flag_wr_end = 1'b0;
  logic rd_req = 1'b0, flag_rd_end = 1'b0;
  logic ref_en, wr_en, rd_en;
  logic [3:0]        sdram_cmd;
  logic [ADDR_W-1:0] sdram_addr;
  logic [1:0]        sdram_bank;
  logic [DATA_W-1:0] sdram_dq_out;
  logic              sdram_dq_oe;
  logic [4:0]        arb_state;
`ifdef SDRAM_ARBIT_WDOG_EN
  logic              wdog_err;
`endif

  int errors = 0;
  int checks = 0;
  logic overlap_seen = 1'b0;

  sdram_arbit #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .WDOG_CYCLES(16)) dut (
    .clk(clk), .rst(rst),
    .flag_init_end(flag_init_end), .init_cmd(C_INIT), .init_addr(A_INIT),
    .ref_req(ref_req), .flag_ref_end(flag_ref_end), .ref_cmd(C_REF),
    .ref_addr(A_REF), .ref_en(ref_en),
    .wr_req(wr_req), .flag_wr_end(flag_wr_end), .wr_cmd(C_WR),
    .wr_addr(A_WR), .wr_bank(B_WR), .wr_data(D_WR), .wr_en(wr_en),
    .rd_req(rd_req), .flag_rd_end(flag_rd_end), .rd_cmd(C_RD),
    .rd_addr(A_RD), .rd_bank(B_RD), .rd_en(rd_en),
    .sdram_cmd(sdram_cmd), .sdram_addr(sdram_addr), .sdram_bank(sdram_bank),
    .sdram_dq_out(sdram_dq_out), .sdram_dq_oe(sdram_dq_oe),
    .arb_state(arb_state)
`ifdef SDRAM_ARBIT_WDOG_EN
    , .wdog_err(wdog_err)
`endif
  );

  always #5 clk = ~clk;

  // More than one grant pulse in the same cycle is never allowed
  always @(negedge clk) begin
    if (({1'b0, ref_en} + {1'b0, wr_en} + {1'b0, rd_en}) > 2'd1) overlap_seen = 1'b1;
  end

  typedef struct {
    logic [7:0] in;   // {rst,init_end,ref_req,ref_end,wr_req,wr_end,rd_req,rd_end}
    logic [4:0] st;
    logic [2:0] en;   // {ref_en,wr_en,rd_en}
  } vec_t;

  vec_t tv[$];

  function automatic vec_t mk(input logic [7:0] in, input logic [4:0] st, input logic [2:0] en);
    vec_t v;
    v.in = in; v.st = st; v.en = en;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [7:0] in);
    {rst, flag_init_end, ref_req, flag_ref_end, wr_req, flag_wr_end, rd_req, flag_rd_end} = in;
  endtask

  // Compare state, grants and the whole bus mux against what the state implies
  task automatic check_outputs(input string tag, input logic [4:0] st, input logic [2:0] en);
    logic [3:0] ec; logic [ADDR_W-1:0] ea; logic [1:0] eb;
    logic [DATA_W-1:0] ed; logic eo;
    ec = 4'b0111; ea = '0; eb = 2'd0; ed = '0; eo = 1'b0;
    if (st == S_IDLE)  begin ec = C_INIT; ea = A_INIT; end
    if (st == S_AREF)  begin ec = C_REF;  ea = A_REF;  end
    if (st == S_WRITE) begin ec = C_WR;   ea = A_WR; eb = B_WR; ed = D_WR; eo = 1'b1; end
    if (st == S_READ)  begin ec = C_RD;   ea = A_RD; eb = B_RD; end
    chk({tag, " state"}, 32'(arb_state), 32'(st));
    chk({tag, " grants"}, 32'({ref_en, wr_en, rd_en}), 32'(en));
    chk({tag, " cmd"}, 32'(sdram_cmd), 32'(ec));
    chk({tag, " addr"}, 32'(sdram_addr), 32'(ea));
    chk({tag, " bank"}, 32'(sdram_bank), 32'(eb));
    chk({tag, " dq_oe"}, 32'(sdram_dq_oe), 32'(eo));
    chk({tag, " dq_out"}, 32'(sdram_dq_out), 32'(ed));
  endtask

  initial begin
    // ---------------- directed table ----------------
    tv.push_back(mk(8'b1000_0000, S_IDLE,  3'b000)); // reset
    tv.push_back(mk(8'b0010_1010, S_IDLE,  3'b000)); // requests ignored in IDLE
    tv.push_back(mk(8'b0000_0000, S_IDLE,  3'b000));
    tv.push_back(mk(8'b0100_0000, S_ARBIT, 3'b000)); // init done
    tv.push_back(mk(8'b0000_1010, S_WRITE, 3'b010)); // contested: write first, no stale refresh
    tv.push_back(mk(8'b0000_1010, S_WRITE, 3'b000)); // grant is one cycle
    tv.push_back(mk(8'b0001_1011, S_WRITE, 3'b000)); // foreign done flags ignored
    tv.push_back(mk(8'b0000_1110, S_ARBIT, 3'b000));
    tv.push_back(mk(8'b0000_1010, S_READ,  3'b001)); // round-robin to read
    tv.push_back(mk(8'b0000_1011, S_ARBIT, 3'b000));
    tv.push_back(mk(8'b0000_1010, S_WRITE, 3'b010));
    tv.push_back(mk(8'b0000_1110, S_ARBIT, 3'b000));
    tv.push_back(mk(8'b0000_1011, S_READ,  3'b001)); // done on grant edge ignored
    tv.push_back(mk(8'b0000_0000, S_READ,  3'b000));
    tv.push_back(mk(8'b0000_0001, S_ARBIT, 3'b000));
    tv.push_back(mk(8'b0010_1000, S_ARBIT, 3'b000)); // refresh pulse blocks write
    tv.push_back(mk(8'b0000_1000, S_AREF,  3'b100));
    tv.push_back(mk(8'b0000_1100, S_AREF,  3'b000));
    tv.push_back(mk(8'b0001_1000, S_ARBIT, 3'b000));
    tv.push_back(mk(8'b0000_1000, S_WRITE, 3'b010));
    tv.push_back(mk(8'b0010_0010, S_WRITE, 3'b000)); // refresh pulse during WRITE
    tv.push_back(mk(8'b0000_0110, S_ARBIT, 3'b000));
    tv.push_back(mk(8'b0000_0010, S_AREF,  3'b100)); // refresh beats pending read
    tv.push_back(mk(8'b0001_0010, S_ARBIT, 3'b000));
    tv.push_back(mk(8'b0000_0010, S_READ,  3'b001));
    tv.push_back(mk(8'b0000_0001, S_ARBIT, 3'b000));
    tv.push_back(mk(8'b0010_0000, S_ARBIT, 3'b000));
    tv.push_back(mk(8'b0010_0000, S_AREF,  3'b100)); // pulse on grant edge re-arms pend
    tv.push_back(mk(8'b0001_0000, S_ARBIT, 3'b000));
    tv.push_back(mk(8'b0000_1000, S_AREF,  3'b100));
    tv.push_back(mk(8'b0001_0000, S_ARBIT, 3'b000));
    tv.push_back(mk(8'b0000_1000, S_WRITE, 3'b010));
    tv.push_back(mk(8'b0000_0110, S_ARBIT, 3'b000));
    tv.push_back(mk(8'b0000_0010, S_READ,  3'b001));
    tv.push_back(mk(8'b1000_0010, S_IDLE,  3'b000)); // reset mid-READ
    tv.push_back(mk(8'b0000_0010, S_IDLE,  3'b000)); // no grant before init
    tv.push_back(mk(8'b0000_0010, S_IDLE,  3'b000));
    tv.push_back(mk(8'b0100_0010, S_ARBIT, 3'b000));
    tv.push_back(mk(8'b0000_0010, S_READ,  3'b001));

    for (int i = 0; i < tv.size(); i++) begin
      drive(tv[i].in);
      tick();
      check_outputs($sformatf("vec%0d", i), tv[i].st, tv[i].en);
    end

    // ---------------- round-robin burst loop ----------------
    drive(8'b1000_0000);
    tick();
    drive(8'b0100_0000);
    tick();
    chk("rr arbit", 32'(arb_state), 32'(S_ARBIT));
    drive(8'b0000_1010);
    for (int g = 0; g < 4; g++) begin
      logic found;
      logic [1:0] kind;
      found = 1'b0;
      for (int c = 0; c < 10 && !found; c++) begin
        tick();
        if (wr_en || rd_en || ref_en) found = 1'b1;
      end
      chk($sformatf("rr grant_seen%0d", g), 32'(found), 32'd1);
      kind = wr_en ? 2'd1 : (rd_en ? 2'd2 : 2'd0);
      chk($sformatf("rr order%0d", g), 32'(kind), (g % 2 == 0) ? 32'd1 : 32'd2);
      repeat (3) tick();
      if (kind == 2'd1) flag_wr_end = 1'b1;
      else flag_rd_end = 1'b1;
      tick();
      flag_wr_end = 1'b0;
      flag_rd_end = 1'b0;
      chk($sformatf("rr back%0d", g), 32'(arb_state), 32'(S_ARBIT));
    end
    drive(8'b0000_0000);
    tick();

`ifdef SDRAM_ARBIT_WDOG_EN
    // ---------------- watchdog abort ----------------
    drive(8'b1000_0000);
    tick();
    chk("wdog reset", 32'(wdog_err), 32'd0);
    drive(8'b0100_0000);
    tick();
    drive(8'b0000_1000);
    tick();
    chk("wdog granted", 32'(arb_state), 32'(S_WRITE));
    drive(8'b0000_0000);
    repeat (15) tick();
    chk("wdog still write", 32'(arb_state), 32'(S_WRITE));
    chk("wdog not yet", 32'(wdog_err), 32'd0);
    tick();
    chk("wdog abort state", 32'(arb_state), 32'(S_ARBIT));
    chk("wdog err set", 32'(wdog_err), 32'd1);
    repeat (5) tick();
    chk("wdog err sticky", 32'(wdog_err), 32'd1);
    drive(8'b1000_0000);
    tick();
    chk("wdog err cleared", 32'(wdog_err), 32'd0);
    drive(8'b0000_0000);
    tick();
`endif

    chk("grant onehot", 32'(overlap_seen), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
